// File: rtl/alu_op_encoder_pkg.sv
// Shared CPU defines: ALU operation codes, RV32I opcode/funct constants,
// and the ALU-class instruction decoder used by the operand encoder.
package alu_op_encoder_pkg;

    // ALU operation codes; the ALU consumes these directly.
    typedef enum logic [3:0] {
        OP_NOP  = 4'b0000,
        OP_ADD  = 4'b0001,
        OP_SUB  = 4'b0010,
        OP_SLT  = 4'b0011,
        OP_AND  = 4'b0100,
        OP_OR   = 4'b0101,
        OP_XOR  = 4'b0110,
        OP_SLL  = 4'b0111,
        OP_SRL  = 4'b1000,
        OP_SRA  = 4'b1001,
        OP_SLTU = 4'b1011
    } alu_op_e;

    // RV32I major opcodes handled by the ALU path.
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // funct3 encodings for OP / OP-IMM.
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    // funct7 encodings: base and alternate (SUB/SRA/SRAI).
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Operand source selects.
    typedef enum logic [1:0] {
        A_SEL_ZERO,
        A_SEL_RS1,
        A_SEL_PC
    } a_sel_e;

    typedef enum logic [2:0] {
        B_SEL_RS2,
        B_SEL_RS2_SHAMT,
        B_SEL_IMM_I,
        B_SEL_SHAMT_I,
        B_SEL_IMM_U
    } b_sel_e;

    typedef struct packed {
        logic    legal;
        alu_op_e op;
        a_sel_e  a_sel;
        b_sel_e  b_sel;
        logic    use_rs1;
        logic    use_rs2;
    } decode_t;

    // One in-flight writeback slot.
    typedef struct packed {
        logic [4:0] rd;
        logic       we;
    } inflight_t;

    // Classify an instruction word; anything not listed stays illegal/NOP.
    function automatic decode_t decode_instr(input logic [31:0] instr);
        decode_t    d;
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        opc       = instr[6:0];
        f3        = instr[14:12];
        f7        = instr[31:25];
        d.legal   = 1'b0;
        d.op      = OP_NOP;
        d.a_sel   = A_SEL_ZERO;
        d.b_sel   = B_SEL_RS2;
        d.use_rs1 = 1'b0;
        d.use_rs2 = 1'b0;
        case (opc)
            OPC_OP: begin
                d.a_sel   = A_SEL_RS1;
                d.use_rs1 = 1'b1;
                d.use_rs2 = 1'b1;
                if (f7 == F7_BASE) begin
                    d.legal = 1'b1;
                    case (f3)
                        F3_ADD_SUB: d.op = OP_ADD;
                        F3_SLL:     begin d.op = OP_SLL; d.b_sel = B_SEL_RS2_SHAMT; end
                        F3_SLT:     d.op = OP_SLT;
                        F3_SLTU:    d.op = OP_SLTU;
                        F3_XOR:     d.op = OP_XOR;
                        F3_SRL_SRA: begin d.op = OP_SRL; d.b_sel = B_SEL_RS2_SHAMT; end
                        F3_OR:      d.op = OP_OR;
                        F3_AND:     d.op = OP_AND;
                    endcase
                end else if (f7 == F7_ALT && f3 == F3_ADD_SUB) begin
                    d.legal = 1'b1;
                    d.op    = OP_SUB;
                end else if (f7 == F7_ALT && f3 == F3_SRL_SRA) begin
                    d.legal = 1'b1;
                    d.op    = OP_SRA;
                    d.b_sel = B_SEL_RS2_SHAMT;
                end
            end
            OPC_OP_IMM: begin
                d.a_sel   = A_SEL_RS1;
                d.b_sel   = B_SEL_IMM_I;
                d.use_rs1 = 1'b1;
                case (f3)
                    F3_ADD_SUB: begin d.legal = 1'b1; d.op = OP_ADD;  end
                    F3_SLT:     begin d.legal = 1'b1; d.op = OP_SLT;  end
                    F3_SLTU:    begin d.legal = 1'b1; d.op = OP_SLTU; end
                    F3_XOR:     begin d.legal = 1'b1; d.op = OP_XOR;  end
                    F3_OR:      begin d.legal = 1'b1; d.op = OP_OR;   end
                    F3_AND:     begin d.legal = 1'b1; d.op = OP_AND;  end
                    F3_SLL: begin
                        d.b_sel = B_SEL_SHAMT_I;
                        if (f7 == F7_BASE) begin
                            d.legal = 1'b1;
                            d.op    = OP_SLL;
                        end
                    end
                    F3_SRL_SRA: begin
                        d.b_sel = B_SEL_SHAMT_I;
                        if (f7 == F7_BASE) begin
                            d.legal = 1'b1;
                            d.op    = OP_SRL;
                        end else if (f7 == F7_ALT) begin
                            d.legal = 1'b1;
                            d.op    = OP_SRA;
                        end
                    end
                endcase
            end
            OPC_LUI: begin
                d.legal = 1'b1;
                d.op    = OP_ADD;
                d.a_sel = A_SEL_ZERO;
                d.b_sel = B_SEL_IMM_U;
            end
            OPC_AUIPC: begin
                d.legal = 1'b1;
                d.op    = OP_ADD;
                d.a_sel = A_SEL_PC;
                d.b_sel = B_SEL_IMM_U;
            end
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/alu_op_encoder_if.sv
// Decode-to-ALU bus: upstream instruction/register-file side and ALU issue side.
interface alu_op_encoder_if #(
    parameter int unsigned XLEN = 32
);
    logic            HALT;
    logic            INSTR_VALID;
    logic [31:0]     INSTR;
    logic [31:0]     PC;
    logic [XLEN-1:0] RS1_DATA;
    logic [XLEN-1:0] RS2_DATA;
    logic [4:0]      RS1_ADDR;
    logic [4:0]      RS2_ADDR;
    logic [3:0]      OP_VAL;
    logic [XLEN-1:0] A;
    logic [XLEN-1:0] B;
    logic [4:0]      RD_ADDR;
    logic            RD_WE;
    logic            STALL;
    logic            ILLEGAL;

    // Upstream (fetch / register file / testbench) view.
    modport master (
        output HALT, INSTR_VALID, INSTR, PC, RS1_DATA, RS2_DATA,
        input  RS1_ADDR, RS2_ADDR, OP_VAL, A, B, RD_ADDR, RD_WE, STALL, ILLEGAL
    );

    // Encoder view.
    modport slave (
        input  HALT, INSTR_VALID, INSTR, PC, RS1_DATA, RS2_DATA,
        output RS1_ADDR, RS2_ADDR, OP_VAL, A, B, RD_ADDR, RD_WE, STALL, ILLEGAL
    );
endinterface

// File: rtl/alu_hazard_tracker.sv
// In-flight destination tracker: a shift register of {rd, we} per issue slot
// and the read-after-write compare against the current source registers.
module alu_hazard_tracker
    import alu_op_encoder_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       halt_i,
    input  logic [4:0] rs1_addr_i,
    input  logic       rs1_used_i,
    input  logic [4:0] rs2_addr_i,
    input  logic       rs2_used_i,
    input  logic [4:0] push_rd_i,
    input  logic       push_we_i,
    output logic       hazard_o
);

    inflight_t pipe_q [DEPTH];
    inflight_t pipe_d [DEPTH];

    // Slot 0 takes the issue of this cycle, older slots move down one.
    always_comb begin
        pipe_d[0].rd = push_rd_i;
        pipe_d[0].we = push_we_i;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    // Shift every non-halted cycle; reset wins over halt.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= '0;
            end
        end else if (!halt_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    // A used, nonzero source matching any writing slot is a hazard.
    always_comb begin
        hazard_o = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (pipe_q[i].we) begin
                if (rs1_used_i && rs1_addr_i != 5'd0 && rs1_addr_i == pipe_q[i].rd) begin
                    hazard_o = 1'b1;
                end
                if (rs2_used_i && rs2_addr_i != 5'd0 && rs2_addr_i == pipe_q[i].rd) begin
                    hazard_o = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/alu_op_encoder.sv
// ALU operand encoder: decodes RV32I ALU-class instructions into a registered
// op code plus operands, interlocking on in-flight register writes.
module alu_op_encoder
    import alu_op_encoder_pkg::*;
#(
    parameter int unsigned INFLIGHT_DEPTH = 2,
    parameter int unsigned XLEN           = 32
) (
    input  logic            CK_REF,
    input  logic            RST_N,
    alu_op_encoder_if.slave bus
);

    typedef enum logic {
        ST_RUN,
        ST_STALL
    } state_e;

    state_e          state_q, state_d;
    alu_op_e         op_q, op_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [4:0]      rd_q, rd_d;
    logic            we_q, we_d;
    logic            ill_q, ill_d;

    decode_t          dec;
    logic             rs1_used;
    logic             rs2_used;
    logic             hazard;
    logic             issue;
    logic signed [11:0] imm12;
    logic signed [31:0] immu32;
    logic [XLEN-1:0]  imm_i;
    logic [XLEN-1:0]  imm_u;
    logic [XLEN-1:0]  shamt_i;
    logic [XLEN-1:0]  shamt_r;
    logic [XLEN-1:0]  pc_x;

    assign dec          = decode_instr(bus.INSTR);
    assign bus.RS1_ADDR = bus.INSTR[19:15];
    assign bus.RS2_ADDR = bus.INSTR[24:20];

    // Only legal ALU instructions read sources; LUI/AUIPC read none.
    assign rs1_used = bus.INSTR_VALID && dec.legal && dec.use_rs1;
    assign rs2_used = bus.INSTR_VALID && dec.legal && dec.use_rs2;

    // Immediates built at XLEN; signed locals give sign extension on resize.
    assign imm12   = bus.INSTR[31:20];
    assign immu32  = {bus.INSTR[31:12], 12'b0};
    assign imm_i   = XLEN'(imm12);
    assign imm_u   = XLEN'(immu32);
    assign shamt_i = XLEN'(bus.INSTR[24:20]);
    assign shamt_r = XLEN'(bus.RS2_DATA[4:0]);
    assign pc_x    = XLEN'(bus.PC);

    alu_hazard_tracker #(
        .DEPTH (INFLIGHT_DEPTH)
    ) u_tracker (
        .clk_i      (CK_REF),
        .rst_ni     (RST_N),
        .halt_i     (bus.HALT),
        .rs1_addr_i (bus.INSTR[19:15]),
        .rs1_used_i (rs1_used),
        .rs2_addr_i (bus.INSTR[24:20]),
        .rs2_used_i (rs2_used),
        .push_rd_i  (rd_d),
        .push_we_i  (we_d),
        .hazard_o   (hazard)
    );

    assign bus.STALL = hazard;
    assign issue     = bus.INSTR_VALID && dec.legal && !hazard;

    // FSM next state: stall while any used source is still being written.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (hazard)  state_d = ST_STALL;
            ST_STALL: if (!hazard) state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    // Issue next state: NOP unless a legal, hazard-free instruction is offered.
    always_comb begin
        op_d  = OP_NOP;
        a_d   = '0;
        b_d   = '0;
        rd_d  = '0;
        we_d  = 1'b0;
        ill_d = bus.INSTR_VALID && !dec.legal;
        if (issue) begin
            op_d = dec.op;
            case (dec.a_sel)
                A_SEL_RS1: a_d = bus.RS1_DATA;
                A_SEL_PC:  a_d = pc_x;
                default:   a_d = '0;
            endcase
            case (dec.b_sel)
                B_SEL_RS2:       b_d = bus.RS2_DATA;
                B_SEL_RS2_SHAMT: b_d = shamt_r;
                B_SEL_IMM_I:     b_d = imm_i;
                B_SEL_SHAMT_I:   b_d = shamt_i;
                B_SEL_IMM_U:     b_d = imm_u;
                default:         b_d = '0;
            endcase
            // Writes to x0 are dropped here so they never create a hazard.
            rd_d = bus.INSTR[11:7];
            we_d = (bus.INSTR[11:7] != 5'd0);
        end
    end

    // State and output registers; reset overrides halt, halt freezes all.
    always_ff @(posedge CK_REF) begin
        if (!RST_N) begin
            state_q <= ST_RUN;
            op_q    <= OP_NOP;
            a_q     <= '0;
            b_q     <= '0;
            rd_q    <= '0;
            we_q    <= 1'b0;
            ill_q   <= 1'b0;
        end else if (!bus.HALT) begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rd_q    <= rd_d;
            we_q    <= we_d;
            ill_q   <= ill_d;
        end
    end

    assign bus.OP_VAL  = op_q;
    assign bus.A       = a_q;
    assign bus.B       = b_q;
    assign bus.RD_ADDR = rd_q;
    assign bus.RD_WE   = we_q;
    assign bus.ILLEGAL = ill_q;

endmodule

// File: tb/tb_alu_op_encoder.sv
// Directed bench for alu_op_encoder: the driver pushes hand-computed expected
// issue results into a queue, the monitor pops one per clock edge and compares.
module tb_alu_op_encoder;

    typedef struct {
        int          idx;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   vec;
    exp_t sb_q[$];

    alu_op_encoder_if #(.XLEN(32)) bus ();

    alu_op_encoder #(
        .INFLIGHT_DEPTH (2),
        .XLEN           (32)
    ) dut (
        .CK_REF (clk),
        .RST_N  (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                           input logic [4:0] rs1, input logic [2:0] f3,
                                           input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                           input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    // Drive one cycle of stimulus, check combinational STALL, queue expectation.
    task automatic step(input logic rstn, input logic halt, input logic valid,
                        input logic [31:0] instr, input logic [31:0] pc,
                        input logic [31:0] rs1d, input logic [31:0] rs2d,
                        input logic exp_stall, input logic [3:0] eop,
                        input logic [31:0] ea, input logic [31:0] eb,
                        input logic [4:0] erd, input logic ewe, input logic eill);
        exp_t e;
        @(negedge clk);
        rst_n           = rstn;
        bus.HALT        = halt;
        bus.INSTR_VALID = valid;
        bus.INSTR       = instr;
        bus.PC          = pc;
        bus.RS1_DATA    = rs1d;
        bus.RS2_DATA    = rs2d;
        #1;
        checks++;
        if (bus.STALL !== exp_stall) begin
            errors++;
            $display("FAIL stall[%0d]: got %b expected %b", vec, bus.STALL, exp_stall);
        end
        e.idx = vec; e.op = eop; e.a = ea; e.b = eb; e.rd = erd; e.we = ewe; e.ill = eill;
        sb_q.push_back(e);
        vec++;
    endtask

    // Monitor: one registered result per clock edge, compared against the queue.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checks++;
                if (bus.OP_VAL !== e.op || bus.A !== e.a || bus.B !== e.b ||
                    bus.RD_ADDR !== e.rd || bus.RD_WE !== e.we || bus.ILLEGAL !== e.ill) begin
                    errors++;
                    $display("FAIL issue[%0d]: got op=%h a=%h b=%h rd=%0d we=%b ill=%b expected op=%h a=%h b=%h rd=%0d we=%b ill=%b",
                             e.idx, bus.OP_VAL, bus.A, bus.B, bus.RD_ADDR, bus.RD_WE, bus.ILLEGAL,
                             e.op, e.a, e.b, e.rd, e.we, e.ill);
                end
            end
        end
    end

    initial begin
        logic [31:0] add_3_1_2, sub_7_3_1, addi_4, srai_5, auipc_6, lw_3, bad_r;
        logic [31:0] add_0_1_2, sll_8, sltu_10, ori_11;
        int          waitc;

        checks = 0;
        errors = 0;
        vec    = 0;
        rst_n           = 1'b0;
        bus.HALT        = 1'b0;
        bus.INSTR_VALID = 1'b0;
        bus.INSTR       = '0;
        bus.PC          = '0;
        bus.RS1_DATA    = '0;
        bus.RS2_DATA    = '0;

        add_3_1_2 = r_type(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3);
        sub_7_3_1 = r_type(7'b0100000, 5'd1, 5'd3, 3'b000, 5'd7);
        addi_4    = i_type(12'hFFF, 5'd0, 3'b000, 5'd4);
        srai_5    = i_type(12'h41F, 5'd5, 3'b101, 5'd5);
        auipc_6   = {20'h12345, 5'd6, 7'b0010111};
        lw_3      = 32'h0000_2183;
        bad_r     = r_type(7'b0100000, 5'd2, 5'd1, 3'b110, 5'd8);
        add_0_1_2 = r_type(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd0);
        sll_8     = r_type(7'b0000000, 5'd2, 5'd1, 3'b001, 5'd8);
        sltu_10   = r_type(7'b0000000, 5'd2, 5'd8, 3'b011, 5'd10);
        ori_11    = i_type(12'h7FF, 5'd1, 3'b110, 5'd11);

        //   rstn halt vld instr      pc           rs1d          rs2d          stall op    a             b             rd   we   ill
        step(1'b0, 1'b0, 1'b0, 32'h0,    32'h0,       32'h0,        32'h0,        1'b0, 4'h0, 32'h0,        32'h0,        5'd0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 32'h0,    32'h0,       32'h0,        32'h0,        1'b0, 4'h0, 32'h0,        32'h0,        5'd0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, add_3_1_2, 32'h0,      32'd5,        32'd7,        1'b0, 4'h1, 32'd5,        32'd7,        5'd3, 1'b1, 1'b0);
        checks++;
        if (bus.RS1_ADDR !== 5'd1 || bus.RS2_ADDR !== 5'd2) begin
            errors++;
            $display("FAIL rs_addr: got %0d,%0d expected 1,2", bus.RS1_ADDR, bus.RS2_ADDR);
        end
        step(1'b1, 1'b0, 1'b1, sub_7_3_1, 32'h0,      32'd100,      32'd30,       1'b1, 4'h0, 32'h0,        32'h0,        5'd0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, sub_7_3_1, 32'h0,      32'd100,      32'd30,       1'b1, 4'h0, 32'h0,        32'h0,        5'd0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, sub_7_3_1, 32'h0,      32'd100,      32'd30,       1'b0, 4'h2, 32'd100,      32'd30,       5'd7, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, addi_4,   32'h0,       32'h0,        32'h0,        1'b0, 4'h1, 32'h0,        32'hFFFF_FFFF, 5'd4, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, srai_5,   32'h0,       32'h8000_0000, 32'h0,       1'b0, 4'h9, 32'h8000_0000, 32'h0000_001F, 5'd5, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, auipc_6,  32'h0000_1000, 32'h0,      32'h0,        1'b0, 4'h1, 32'h0000_1000, 32'h1234_5000, 5'd6, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, lw_3,     32'h0,       32'h0,        32'h0,        1'b0, 4'h0, 32'h0,        32'h0,        5'd0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1, bad_r,    32'h0,       32'd9,        32'd9,        1'b0, 4'h0, 32'h0,        32'h0,        5'd0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 32'h0,    32'h0,       32'h0,        32'h0,        1'b0, 4'h0, 32'h0,        32'h0,        5'd0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, add_0_1_2, 32'h0,      32'd5,        32'd7,        1'b0, 4'h1, 32'd5,        32'd7,        5'd0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, sll_8,    32'h0,       32'd1,        32'hFFFF_FF23, 1'b0, 4'h7, 32'd1,       32'd3,        5'd8, 1'b1, 1'b0);
        // Halt holds the SLL result although a different legal instruction is offered.
        step(1'b1, 1'b1, 1'b1, add_3_1_2, 32'h0,      32'd5,        32'd7,        1'b0, 4'h7, 32'd1,        32'd3,        5'd8, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, sltu_10,  32'h0,       32'd1,        32'd2,        1'b1, 4'h0, 32'h0,        32'h0,        5'd0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, sltu_10,  32'h0,       32'd1,        32'd2,        1'b1, 4'h0, 32'h0,        32'h0,        5'd0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, sltu_10,  32'h0,       32'd1,        32'd2,        1'b1, 4'h0, 32'h0,        32'h0,        5'd0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, sltu_10,  32'h0,       32'd1,        32'd2,        1'b1, 4'h0, 32'h0,        32'h0,        5'd0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, sltu_10,  32'h0,       32'd1,        32'd2,        1'b1, 4'h0, 32'h0,        32'h0,        5'd0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, sltu_10,  32'h0,       32'd1,        32'd2,        1'b0, 4'hB, 32'd1,        32'd2,        5'd10, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'h0,    32'h0,       32'h0,        32'h0,        1'b0, 4'h0, 32'h0,        32'h0,        5'd0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, ori_11,   32'h0,       32'h100,      32'h0,        1'b0, 4'h5, 32'h100,      32'h7FF,      5'd11, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'h0,    32'h0,       32'h0,        32'h0,        1'b0, 4'h0, 32'h0,        32'h0,        5'd0, 1'b0, 1'b0);

        waitc = 0;
        while (sb_q.size() > 0 && waitc < 10) begin
            @(negedge clk);
            waitc++;
        end
        if (sb_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending results expected 0", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
